window_scan_ctrl: RTL and testbench
===================================

Name: window_scan_ctrl

Overview:
Frame sequencer for the 3x3 line-buffer window kernel used by the median filter. It accepts a raster pixel stream through a valid/ready handshake and drives the kernel shift enable. It tracks the row and column of every accepted pixel. It flags the cycles when the kernel's 9 taps form a window that lies fully inside the image, and reports the window centre coordinate. It also sequences frame start, abort and end.

Parameters:
IMG_Width, 256, pixels per row (>= 3)
IMG_Height, 256, rows per frame (>= 3)
COL_W, 8, column counter width; must satisfy 2^COL_W >= IMG_Width
ROW_W, 8, row counter width; must satisfy 2^ROW_W >= IMG_Height

Ports:
CLK  input  1  clock; all state updates on the rising edge
CLR  input  1  reset, asynchronous, active-low
Start  input  1  one-cycle pulse that begins a frame; honoured only in IDLE
Abort  input  1  synchronous; returns the block to IDLE from any state
Pix_Valid  input  1  upstream pixel present
Out_Stall  input  1  downstream back-pressure; blocks acceptance
Pix_Ready  output  1  block can accept a pixel this cycle
Shift_EN  output  1  kernel shift enable (drives the kernel's Valid_IN)
Win_Valid  output  1  kernel taps hold a fully interior 3x3 window
Win_Row  output  ROW_W  row of the window centre (R11)
Win_Col  output  COL_W  column of the window centre (R11)
Busy  output  1  high in FILL, STREAM and DONE
Frame_Done  output  1  one-cycle pulse at frame end

Behaviour:
- Reset (CLR=0, asynchronous): state=IDLE; row and column counters = 0; Win_Valid=0; Win_Row=0; Win_Col=0; Frame_Done=0. Pix_Ready, Shift_EN and Busy are 0 in IDLE.
- Pix_Ready = (state is FILL or STREAM) and !Out_Stall. This is combinational.
- Shift_EN = Pix_Valid & Pix_Ready. This is combinational. A pixel is "accepted" on each cycle Shift_EN=1.
- Counters (c, r) give the position of the next pixel to be accepted.
  - On accept: c increments. When c=IMG_Width-1, c wraps to 0 and r increments.
- State machine:
  - IDLE: on Start, go to FILL and clear c and r. Start in any other state is ignored.
  - FILL: go to STREAM on accept of pixel (r=2, c=1).
  - STREAM: go to DONE on accept of pixel (IMG_Height-1, IMG_Width-1).
  - DONE: lasts exactly 1 cycle with Frame_Done=1, then go to IDLE.
- Abort=1 forces IDLE next cycle and clears the counters. Abort has priority over Start and over any accept in the same cycle. That cycle's accept is still shifted into the kernel, but its window is discarded (Win_Valid=0 next cycle).
- Window flag (registered, latency 1):
  - Win_Valid(t+1) = 1 iff a pixel (r, c) with r >= 2 and c >= 2 was accepted at cycle t.
  - On that same cycle, Win_Row = r-1 and Win_Col = c-1 are registered.
  - Win_Valid is 0 on any cycle with no accept in the prior cycle, including during stalls. Win_Row and Win_Col hold their last value.
- Columns 0 and 1 of each row never produce Win_Valid; these are the row-wrap windows. Rows 0 and 1 never produce Win_Valid. Each frame therefore produces exactly (IMG_Width-2)*(IMG_Height-2) windows.
- The final window's Win_Valid coincides with the DONE cycle (Frame_Done=1).
- Kernel storage is not cleared between frames. Stale data is never flagged valid, because the first valid window needs rows 0..2 of the new frame.
- Pix_Valid while Pix_Ready=0 is ignored; the upstream source must hold the pixel.

Optional Feature:
WIN_COUNT_EN:
- Defined: adds output Win_Count (width ROW_W+COL_W). It increments on each Win_Valid cycle, clears on Start in IDLE, on Abort and on reset, and holds its value after DONE until the next Start.
- Undefined: the port and its counter are absent; all other behaviour is identical.

Decomposition:
- Shared package: state encoding (IDLE=2'd0, FILL=2'd1, STREAM=2'd2, DONE=2'd3); FILL exit coordinate constants (row 2, column 1); window margin constant = 2.
- One natural sub-module, raster_counter: column/row counter pair with enable, wrap and last-pixel flag; reusable for the kernel's own valid tracking.

Test Plan:
- IMG_Width=4, IMG_Height=4, Start, then Pix_Valid held high for 16 cycles -> 4 Win_Valid pulses with (Win_Row, Win_Col) = (1,1), (1,2), (2,1), (2,2). Frame_Done coincides with the (2,2) pulse; Busy then drops to 0.
- Same frame with Out_Stall=1 for 3 cycles mid-row 2 -> Pix_Ready=0 and Shift_EN=0 during the stall; no Win_Valid is emitted for stalled cycles; the same 4 windows are still produced.
- Abort asserted while accepting pixel (2,3) -> no Win_Valid the next cycle; state returns to IDLE; a new Start produces a full 4-window frame.
- Start pulsed during STREAM -> ignored; counters unaffected; window count still 4.
- CLR driven low mid-frame asynchronously -> all outputs go to 0 immediately without waiting for a clock edge; after release the block sits in IDLE until Start.
- With WIN_COUNT_EN, a 5x4 frame -> Win_Count = 6 after Frame_Done; Start clears it to 0.

Source files
------------

// File: rtl/window_scan_ctrl_pkg.sv
// Shared types and constants for the 3x3 window scan controller.
package window_scan_ctrl_pkg;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        FILL   = 2'd1,
        STREAM = 2'd2,
        DONE   = 2'd3
    } scan_state_t;

    // Accepting this pixel means the kernel has seen rows 0..2 of the frame.
    localparam int FILL_EXIT_ROW = 2;
    localparam int FILL_EXIT_COL = 1;
    localparam int WIN_MARGIN    = 2;

endpackage

// File: rtl/window_scan_ctrl_if.sv
// Pixel handshake and window report bundle between the source, the scan controller and its consumers.
interface window_scan_ctrl_if #(
    parameter int ROW_W = 8,
    parameter int COL_W = 8
);
    logic             Pix_Valid;
    logic             Out_Stall;
    logic             Pix_Ready;
    logic             Shift_EN;
    logic             Win_Valid;
    logic [ROW_W-1:0] Win_Row;
    logic [COL_W-1:0] Win_Col;

    modport master (
        output Pix_Valid, Out_Stall,
        input  Pix_Ready, Shift_EN, Win_Valid, Win_Row, Win_Col
    );

    modport slave (
        input  Pix_Valid, Out_Stall,
        output Pix_Ready, Shift_EN, Win_Valid, Win_Row, Win_Col
    );
endinterface

// File: rtl/window_scan_ctrl_raster_counter.sv
// Column/row position counter for a raster scan with sync clear, enable and last-pixel flag.
module raster_counter #(
    parameter int WIDTH  = 256,
    parameter int HEIGHT = 256,
    parameter int COL_W  = 8,
    parameter int ROW_W  = 8
) (
    input  logic             clk_sys,
    input  logic             rst_b,
    input  logic             clr,
    input  logic             en,
    output logic [COL_W-1:0] col,
    output logic [ROW_W-1:0] row,
    output logic             last
);
    logic col_end;
    logic row_end;

    assign col_end = (col == COL_W'(WIDTH - 1));
    assign row_end = (row == ROW_W'(HEIGHT - 1));
    assign last    = col_end && row_end;

    always_ff @(posedge clk_sys or negedge rst_b) begin
        if (!rst_b) begin
            col <= '0;
            row <= '0;
        end else if (clr) begin
            col <= '0;
            row <= '0;
        end else if (en) begin
            if (col_end) begin
                col <= '0;
                row <= row_end ? '0 : row + ROW_W'(1);
            end else begin
                col <= col + COL_W'(1);
            end
        end
    end

endmodule

// File: rtl/window_scan_ctrl.sv
// Frame sequencer for the 3x3 median kernel: gates pixel acceptance and flags interior windows.
// Optional Win_Count output is built when WIN_COUNT_EN is defined.
//   state  | meaning
//   IDLE   | waiting for Start, no pixels accepted
//   FILL   | accepting rows 0..2 until the first full kernel column set
//   STREAM | accepting the rest of the frame
//   DONE   | single cycle, Frame_Done pulse
module window_scan_ctrl
    import window_scan_ctrl_pkg::*;
#(
    parameter int IMG_Width  = 256,
    parameter int IMG_Height = 256,
    parameter int COL_W      = 8,
    parameter int ROW_W      = 8
) (
    input  logic                   CLK,
    input  logic                   CLR,
    input  logic                   Start,
    input  logic                   Abort,
    window_scan_ctrl_if.slave      bus,
    output logic                   Busy,
    output logic                   Frame_Done
`ifdef WIN_COUNT_EN
    ,
    output logic [ROW_W+COL_W-1:0] Win_Count
`endif
);
    scan_state_t      state;
    scan_state_t      state_nxt;
    logic             accept;
    logic             cnt_clr;
    logic             last_pix;
    logic             fill_exit;
    logic             win_hit;
    logic [COL_W-1:0] col;
    logic [ROW_W-1:0] row;

    assign bus.Pix_Ready = ((state == FILL) || (state == STREAM)) && !bus.Out_Stall;
    assign bus.Shift_EN  = bus.Pix_Valid && bus.Pix_Ready;
    assign accept        = bus.Shift_EN;
    assign cnt_clr       = Abort || ((state == IDLE) && Start);
    assign fill_exit     = (row == ROW_W'(FILL_EXIT_ROW)) && (col == COL_W'(FILL_EXIT_COL));
    // An aborted accept still shifts into the kernel but its window is dropped.
    assign win_hit       = accept && !Abort
                           && (row >= ROW_W'(WIN_MARGIN)) && (col >= COL_W'(WIN_MARGIN));

    raster_counter #(
        .WIDTH  (IMG_Width),
        .HEIGHT (IMG_Height),
        .COL_W  (COL_W),
        .ROW_W  (ROW_W)
    ) u_pos (
        .clk_sys (CLK),
        .rst_b   (CLR),
        .clr     (cnt_clr),
        .en      (accept),
        .col     (col),
        .row     (row),
        .last    (last_pix)
    );

    always_ff @(posedge CLK or negedge CLR) begin
        if (!CLR) state <= IDLE;
        else      state <= state_nxt;
    end

    always_comb begin
        state_nxt  = state;
        Busy       = (state != IDLE);
        Frame_Done = (state == DONE);
        case (state)
            IDLE:   if (Start) state_nxt = FILL;
            FILL:   if (accept && fill_exit) state_nxt = STREAM;
            STREAM: if (accept && last_pix) state_nxt = DONE;
            DONE:   state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
        if (Abort) state_nxt = IDLE;
    end

    always_ff @(posedge CLK or negedge CLR) begin
        if (!CLR) begin
            bus.Win_Valid <= 1'b0;
            bus.Win_Row   <= '0;
            bus.Win_Col   <= '0;
        end else begin
            bus.Win_Valid <= win_hit;
            if (win_hit) begin
                bus.Win_Row <= row - ROW_W'(1);
                bus.Win_Col <= col - COL_W'(1);
            end
        end
    end

`ifdef WIN_COUNT_EN
    always_ff @(posedge CLK or negedge CLR) begin
        if (!CLR)               Win_Count <= '0;
        else if (cnt_clr)       Win_Count <= '0;
        else if (bus.Win_Valid) Win_Count <= Win_Count + (ROW_W+COL_W)'(1);
    end
`endif

endmodule

// File: tb/tb_window_scan_ctrl.sv
// Directed bench for window_scan_ctrl on a 4x4 frame; Win_Count checks build with WIN_COUNT_EN.
module tb_window_scan_ctrl;

    logic CLK = 1'b0;
    logic CLR = 1'b0;
    logic Start = 1'b0;
    logic Abort = 1'b0;
    logic Busy;
    logic Frame_Done;
`ifdef WIN_COUNT_EN
    logic [15:0] win_count;
`endif

    int total = 0;
    int bad   = 0;
    logic [15:0] win_q[$];

    window_scan_ctrl_if #(.ROW_W(8), .COL_W(8)) bus_if();

    window_scan_ctrl #(
        .IMG_Width  (4),
        .IMG_Height (4),
        .COL_W      (8),
        .ROW_W      (8)
    ) dut (
        .CLK        (CLK),
        .CLR        (CLR),
        .Start      (Start),
        .Abort      (Abort),
        .bus        (bus_if.slave),
        .Busy       (Busy),
        .Frame_Done (Frame_Done)
`ifdef WIN_COUNT_EN
        ,
        .Win_Count  (win_count)
`endif
    );

    always #5 CLK = ~CLK;

    always @(negedge CLK) begin
        if (CLR === 1'b1 && bus_if.Win_Valid === 1'b1)
            win_q.push_back({bus_if.Win_Row, bus_if.Win_Col});
    end

    task automatic tick();
        @(posedge CLK);
        #1;
    endtask

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp)
        else begin
            bad++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    task automatic run_frame(input string tag, input int stall_at, input int stall_len, input int start_at);
        logic [15:0] exp_w [4];
        int edges;
        bit done;
        exp_w = '{16'h0101, 16'h0102, 16'h0201, 16'h0202};
        win_q.delete();
        Start = 1'b1;
        tick();
        Start = 1'b0;
        check({tag, "_busy"}, 32'(Busy), 1);
        edges = 0;
        done  = 1'b0;
        while (!done && edges < 60) begin
            bus_if.Pix_Valid = 1'b1;
            bus_if.Out_Stall = (edges >= stall_at && edges < stall_at + stall_len);
            Start = (edges == start_at);
            #1;
            if (bus_if.Out_Stall) begin
                check({tag, "_stall_ready"}, 32'(bus_if.Pix_Ready), 0);
                check({tag, "_stall_shift"}, 32'(bus_if.Shift_EN), 0);
            end
            if (edges > stall_at && edges <= stall_at + stall_len)
                check({tag, "_stall_win"}, 32'(bus_if.Win_Valid), 0);
            tick();
            edges++;
            done = Frame_Done;
        end
        Start = 1'b0;
        bus_if.Out_Stall = 1'b0;
        check({tag, "_done_seen"}, 32'(done), 1);
        check({tag, "_edges"}, 32'(edges), 32'(16 + stall_len));
        check({tag, "_last_win"}, 32'(bus_if.Win_Valid), 1);
        check({tag, "_last_row"}, 32'(bus_if.Win_Row), 2);
        check({tag, "_last_col"}, 32'(bus_if.Win_Col), 2);
        bus_if.Pix_Valid = 1'b0;
        tick();
        check({tag, "_end_busy"}, 32'(Busy), 0);
        check({tag, "_end_done"}, 32'(Frame_Done), 0);
        check({tag, "_end_win"}, 32'(bus_if.Win_Valid), 0);
        check({tag, "_nwin"}, 32'(win_q.size()), 4);
        for (int i = 0; i < 4; i++)
            if (i < win_q.size())
                check($sformatf("%s_win%0d", tag, i), 32'(win_q[i]), 32'(exp_w[i]));
`ifdef WIN_COUNT_EN
        check({tag, "_count"}, 32'(win_count), 4);
`endif
    endtask

    initial begin
        bus_if.Pix_Valid = 1'b1;
        bus_if.Out_Stall = 1'b0;
        #3;
        check("rst_ready", 32'(bus_if.Pix_Ready), 0);
        check("rst_shift", 32'(bus_if.Shift_EN), 0);
        check("rst_win",   32'(bus_if.Win_Valid), 0);
        check("rst_row",   32'(bus_if.Win_Row), 0);
        check("rst_col",   32'(bus_if.Win_Col), 0);
        check("rst_busy",  32'(Busy), 0);
        check("rst_done",  32'(Frame_Done), 0);
        CLR = 1'b1;
        tick();
        tick();
        check("idle_busy",  32'(Busy), 0);
        check("idle_ready", 32'(bus_if.Pix_Ready), 0);
        bus_if.Pix_Valid = 1'b0;

        run_frame("plain", 100, 0, -1);
        run_frame("stall", 9, 3, -1);

        // abort while pixel (2,3) is being accepted
        win_q.delete();
        Start = 1'b1;
        tick();
        Start = 1'b0;
        bus_if.Pix_Valid = 1'b1;
        repeat (11) tick();
        Abort = 1'b1;
        #1;
        check("abort_shift", 32'(bus_if.Shift_EN), 1);
        tick();
        Abort = 1'b0;
        check("abort_win",  32'(bus_if.Win_Valid), 0);
        check("abort_busy", 32'(Busy), 0);
        check("abort_row",  32'(bus_if.Win_Row), 1);
        check("abort_col",  32'(bus_if.Win_Col), 1);
        check("abort_nwin", 32'(win_q.size()), 1);
`ifdef WIN_COUNT_EN
        check("abort_count", 32'(win_count), 0);
`endif
        tick();
        check("abort_idle_ready", 32'(bus_if.Pix_Ready), 0);
        check("abort_idle_busy",  32'(Busy), 0);
        bus_if.Pix_Valid = 1'b0;
        run_frame("post_abort", 100, 0, -1);

        run_frame("start_stream", 100, 0, 12);

        // asynchronous reset mid-frame, away from any clock edge
        Start = 1'b1;
        tick();
        Start = 1'b0;
        bus_if.Pix_Valid = 1'b1;
        repeat (11) tick();
        check("pre_rst_win", 32'(bus_if.Win_Valid), 1);
        #2;
        CLR = 1'b0;
        #1;
        check("arst_win",   32'(bus_if.Win_Valid), 0);
        check("arst_row",   32'(bus_if.Win_Row), 0);
        check("arst_col",   32'(bus_if.Win_Col), 0);
        check("arst_busy",  32'(Busy), 0);
        check("arst_ready", 32'(bus_if.Pix_Ready), 0);
        check("arst_shift", 32'(bus_if.Shift_EN), 0);
        check("arst_done",  32'(Frame_Done), 0);
        #1;
        CLR = 1'b1;
        tick();
        tick();
        check("post_rst_busy",  32'(Busy), 0);
        check("post_rst_ready", 32'(bus_if.Pix_Ready), 0);
        bus_if.Pix_Valid = 1'b0;
        run_frame("post_rst", 100, 0, -1);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
